uart_rx_fifo: RTL and testbench
===============================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter DATA_BITS, default 8, meaning data bits per frame (5..9).
REQ-002 Parameter FIFO_DEPTH, default 4, meaning receive FIFO entries (power of two, >=2).
REQ-003 Parameter DIV_WIDTH, default 24, meaning width of the bit-period divider.
REQ-004 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 Port reset  input  1  synchronous, active-high reset.
REQ-006 Port rx  input  1  asynchronous serial line; idle high.
REQ-007 Port div  input  DIV_WIDTH  bit period minus one in clk cycles; legal values >=3, held stable while a frame is in flight.
REQ-008 Port parity_en  input  1  1 = one parity bit follows the data bits.
REQ-009 Port parity_odd  input  1  1 = odd parity, 0 = even; ignored when parity_en=0.
REQ-010 Port pull  input  1  pop the FIFO head; ignored when rx_empty=1.
REQ-011 Port clr_err  input  1  clears all sticky error flags.
REQ-012 Port dout  output  DATA_BITS  FIFO head word (first-word fall-through); zero when empty.
REQ-013 Port rx_empty  output  1  FIFO holds no words.
REQ-014 Port rx_full  output  1  FIFO holds FIFO_DEPTH words.
REQ-015 Port frame_err, parity_err, overrun  output  1 each  sticky error flags.

Function
REQ-016 The block SHALL pass rx through a two-flop synchroniser whose flops reset to 1; all decisions use the synchronised value rs.
REQ-017 The FSM SHALL have the states IDLE, START, DATA, PARITY, STOP.
REQ-018 IDLE SHALL move to START only on a falling edge of rs (previous 1, current 0) and load the bit counter with div>>1.
REQ-019 Each state SHALL decrement the bit counter once per cycle and sample rs in the cycle the counter equals 0, then reload the counter with div.
REQ-020 START SHALL return to IDLE with no other effect if the sample is 1 (false start); otherwise it SHALL move to DATA.
REQ-021 DATA SHALL shift in exactly DATA_BITS samples LSB first, then move to PARITY if parity_en=1, else to STOP.
REQ-022 PARITY SHALL compare the sample with the XOR of the data bits, XORed with parity_odd, and record any mismatch for the frame.
REQ-023 STOP SHALL return to IDLE after its sample; a sample of 0 SHALL set frame_err and discard the word.
REQ-024 A word with a parity mismatch and a valid stop bit SHALL be discarded and SHALL set parity_err.
REQ-025 A good word SHALL be written to the FIFO at the end of the stop-sample cycle; rx_empty SHALL be low in the following cycle.
REQ-026 A good word arriving while the FIFO is full and pull=0 SHALL be dropped, SHALL set overrun, and SHALL leave the FIFO contents unchanged.
REQ-027 A simultaneous push and pull while full SHALL perform both, with no overrun; a simultaneous push and pull while empty SHALL leave the new word at the head.
REQ-028 pull SHALL advance the head by one entry per cycle; the pointers SHALL wrap modulo FIFO_DEPTH; an occupancy count of width clog2(FIFO_DEPTH)+1 SHALL drive rx_empty and rx_full.
REQ-029 Error flags SHALL remain set until clr_err=1; if clr_err coincides with a new error event, the flag SHALL end set.
REQ-030 After a frame error the FSM SHALL not start a new frame until a new falling edge of rs, so a held-low line (break) yields a single frame_err.

Reset
REQ-031 While reset=1: FSM in IDLE, counters 0, FIFO empty (rx_empty=1, rx_full=0, dout=0), all error flags 0, synchroniser flops 1.
REQ-032 Reset mid-frame SHALL abandon the frame without pushing and without setting any flag.

Verification
REQ-033 div=9, 8N1, byte 0xA5 (10 clk/bit) -> rx_empty falls about 97 clk after the start edge; dout=0xA5; pull -> rx_empty=1, dout=0.
REQ-034 rx low for 3 clk, then high, div=9 -> FSM returns to IDLE; FIFO stays empty; no flags set.
REQ-035 parity_en=1, parity_odd=1, byte 0x03 sent with parity bit 0 -> parity_err=1, FIFO empty; clr_err pulse -> parity_err=0.
REQ-036 Byte 0x55 with stop bit 0, line then held low for 50 bit times -> exactly one frame_err; no push; the next good byte after the line returns high is received.
REQ-037 FIFO_DEPTH=4: bytes 0x11,0x22,0x33,0x44,0x55 with no pulls -> rx_full=1, overrun=1; pops return 0x11,0x22,0x33,0x44, then rx_empty=1.
REQ-038 reset asserted mid-DATA for 1 clk -> all outputs at reset values; a following byte 0x3C is received correctly; DATA_BITS=7 build with byte 0x7F -> dout=0x7F.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// UART receiver: 2-flop synchroniser, mid-bit sampling FSM with optional parity,
// and a first-word fall-through receive FIFO with sticky error flags.
module uart_rx_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_WIDTH  = 24
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  input  logic [DIV_WIDTH-1:0] div,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  input  logic                 pull,
  input  logic                 clr_err,
  output logic [DATA_BITS-1:0] dout,
  output logic                 rx_empty,
  output logic                 rx_full,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = $clog2(DATA_BITS + 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t               state_q, state_d;
  logic                 sync1_q, sync1_d, sync2_q, sync2_d, rs_prev_q, rs_prev_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_bad_q, par_bad_d;
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 frame_err_q, frame_err_d, parity_err_q, parity_err_d;
  logic                 overrun_q, overrun_d;
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];

  logic rs, sample, push, fe_evt, pe_evt, ovr_evt, full, push_ok, pull_ok;

  always_comb begin
    sync1_d   = rx;
    sync2_d   = sync1_q;
    rs_prev_d = sync2_q;
    rs        = sync2_q;
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_bad_d = par_bad_q;
    push      = 1'b0;
    fe_evt    = 1'b0;
    pe_evt    = 1'b0;
    sample    = (cnt_q == '0);
    case (state_q)
      // Only a genuine 1->0 transition starts a frame, so a held-low break
      // after a frame error cannot retrigger reception.
      IDLE: if (rs_prev_q && !rs) begin
        state_d   = START;
        cnt_d     = div >> 1;
        par_bad_d = 1'b0;
      end
      default: begin
        if (!sample) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          cnt_d = div;
          case (state_q)
            START: begin
              if (rs) state_d = IDLE;
              else begin
                state_d   = DATA;
                bit_cnt_d = '0;
              end
            end
            DATA: begin
              shift_d   = {rs, shift_q[DATA_BITS-1:1]};
              bit_cnt_d = bit_cnt_q + 1'b1;
              if (bit_cnt_q == BW'(DATA_BITS - 1))
                state_d = parity_en ? PARITY : STOP;
            end
            PARITY: begin
              par_bad_d = rs != (^shift_q ^ parity_odd);
              state_d   = STOP;
            end
            STOP: begin
              state_d = IDLE;
              if (!rs)           fe_evt = 1'b1;
              else if (par_bad_q) pe_evt = 1'b1;
              else               push   = 1'b1;
            end
            default: state_d = IDLE;
          endcase
        end
      end
    endcase
  end

  // A pull alongside a push frees the slot, so a full FIFO still accepts the word.
  always_comb begin
    full     = (count_q == CW'(FIFO_DEPTH));
    pull_ok  = pull && (count_q != '0);
    push_ok  = push && (!full || pull_ok);
    ovr_evt  = push && full && !pull;
    wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pull_ok ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q + {{PW{1'b0}}, push_ok} - {{PW{1'b0}}, pull_ok};
    frame_err_d  = (frame_err_q  & ~clr_err) | fe_evt;
    parity_err_d = (parity_err_q & ~clr_err) | pe_evt;
    overrun_d    = (overrun_q    & ~clr_err) | ovr_evt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      rs_prev_q    <= 1'b1;
      cnt_q        <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      par_bad_q    <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      rs_prev_q    <= rs_prev_d;
      cnt_q        <= cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      par_bad_q    <= par_bad_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      overrun_q    <= overrun_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= shift_q;
  end

  assign dout       = (count_q == '0) ? '0 : mem_q[rd_ptr_q];
  assign rx_empty   = (count_q == '0);
  assign rx_full    = full;
  assign frame_err  = frame_err_q;
  assign parity_err = parity_err_q;
  assign overrun    = overrun_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed scenarios plus random frames checked against
// a queue-based model of frame outcomes (8-bit build) and a 7-bit build.
module tb_uart_rx_fifo;
  localparam int DW = 24, DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset, line, sel7, parity_en, parity_odd, pull, clr_err, pull7;
  logic [DW-1:0] div;
  logic          rx8, rx7;
  logic [7:0]    dout;
  logic [6:0]    dout7;
  logic          rx_empty, rx_full, frame_err, parity_err, overrun;
  logic          rx_empty7, rx_full7, frame_err7, parity_err7, overrun7;

  always #5 clk = ~clk;
  assign rx8 = sel7 ? 1'b1 : line;
  assign rx7 = sel7 ? line : 1'b1;

  uart_rx_fifo #(.DATA_BITS(8), .FIFO_DEPTH(DEPTH), .DIV_WIDTH(DW)) u_dut (
    .clk(clk), .reset(reset), .rx(rx8), .div(div), .parity_en(parity_en),
    .parity_odd(parity_odd), .pull(pull), .clr_err(clr_err), .dout(dout),
    .rx_empty(rx_empty), .rx_full(rx_full), .frame_err(frame_err),
    .parity_err(parity_err), .overrun(overrun));

  uart_rx_fifo #(.DATA_BITS(7), .FIFO_DEPTH(DEPTH), .DIV_WIDTH(DW)) u_dut7 (
    .clk(clk), .reset(reset), .rx(rx7), .div(div), .parity_en(parity_en),
    .parity_odd(parity_odd), .pull(pull7), .clr_err(clr_err), .dout(dout7),
    .rx_empty(rx_empty7), .rx_full(rx_full7), .frame_err(frame_err7),
    .parity_err(parity_err7), .overrun(overrun7));

  int n_vec = 0, n_bad = 0;
  logic [7:0] mq[$];
  bit m_fe, m_pe, m_ov;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".empty"}, rx_empty, mq.size() == 0);
    chk({tag, ".full"},  rx_full,  mq.size() == DEPTH);
    chk({tag, ".dout"},  dout,     mq.size() != 0 ? mq[0] : 8'h00);
    chk({tag, ".fe"},    frame_err,  m_fe);
    chk({tag, ".pe"},    parity_err, m_pe);
    chk({tag, ".ov"},    overrun,    m_ov);
  endtask

  // Outcome of one frame in terms of the line protocol, not the receiver's internals.
  task automatic model_frame(input logic [7:0] data, input bit pen, input bit bad_par,
                             input bit stop, input bit pull_same);
    if (pull_same && mq.size() != 0) void'(mq.pop_front());
    if (!stop)                     m_fe = 1'b1;
    else if (pen && bad_par)       m_pe = 1'b1;
    else if (mq.size() == DEPTH)   m_ov = 1'b1;
    else                           mq.push_back(data);
  endtask

  // Negedge index 0 carries the start bit; the receiver samples the stop bit in
  // the cycle at index 3 + div/2 + (bits after start)*(div+1).
  task automatic send_frame(input logic [8:0] data, input int nb, input bit pen,
                            input bit podd, input bit bad_par, input bit stop,
                            input bit clr_at_stop, input bit pull_at_stop,
                            input bit hold_low, output bit e_s, output bit e_s1);
    bit bits[$];
    bit par;
    int p, s, total;
    p = int'(div) + 1;
    par = podd;
    bits.push_back(1'b0);
    for (int i = 0; i < nb; i++) begin
      bits.push_back(data[i]);
      par ^= data[i];
    end
    if (pen) bits.push_back(par ^ bad_par);
    bits.push_back(stop);
    total = bits.size() * p;
    s = 3 + int'(div >> 1) + (nb + int'(pen) + 1) * p;
    e_s = 1'b0;
    e_s1 = 1'b0;
    for (int i = 0; i < total + p + 2; i++) begin
      @(negedge clk);
      if (i == s)     e_s  = rx_empty;
      if (i == s + 1) e_s1 = rx_empty;
      line    = (i < total) ? bits[i / p] : !hold_low;
      clr_err = clr_at_stop && (i == s);
      pull    = pull_at_stop && (i == s);
    end
    @(negedge clk);
    clr_err = 1'b0;
    pull    = 1'b0;
  endtask

  task automatic do_pull(input string tag);
    @(negedge clk);
    chk({tag, ".head"}, dout, mq.size() != 0 ? mq[0] : 8'h00);
    pull = 1'b1;
    @(negedge clk);
    pull = 1'b0;
    if (mq.size() != 0) void'(mq.pop_front());
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    m_fe = 1'b0;
    m_pe = 1'b0;
    m_ov = 1'b0;
  endtask

  task automatic good_frame(input logic [7:0] d, input string tag);
    bit a, b;
    send_frame({1'b0, d}, 8, parity_en, parity_odd, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, a, b);
    model_frame(d, parity_en, 1'b0, 1'b1, 1'b0);
    check_state(tag);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit e_s, e_s1;
    logic [7:0] fill [5];
    reset = 1'b1; line = 1'b1; sel7 = 1'b0; parity_en = 1'b0; parity_odd = 1'b0;
    pull = 1'b0; clr_err = 1'b0; pull7 = 1'b0; div = 24'd9;
    repeat (3) @(negedge clk);
    check_state("reset");
    chk("reset.empty7", rx_empty7, 1'b1);
    chk("reset.dout7", dout7, 7'h00);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // 8N1 0xA5 at 10 clk/bit: word lands right after the stop sample (~97 clk)
    send_frame(9'h0A5, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, e_s, e_s1);
    chk("lat.pre",  e_s,  1'b1);
    chk("lat.post", e_s1, 1'b0);
    model_frame(8'hA5, 1'b0, 1'b0, 1'b1, 1'b0);
    check_state("a5");
    do_pull("a5");
    check_state("a5.pop");

    // glitch shorter than half a bit is a false start
    @(negedge clk); line = 1'b0;
    repeat (3) @(negedge clk);
    line = 1'b1;
    repeat (40) @(negedge clk);
    check_state("false_start");
    good_frame(8'h5A, "after_false");
    do_pull("after_false");

    // odd parity, 0x03 with parity bit 0 is a mismatch
    parity_en = 1'b1; parity_odd = 1'b1;
    send_frame(9'h003, 8, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, e_s, e_s1);
    model_frame(8'h03, 1'b1, 1'b1, 1'b1, 1'b0);
    check_state("par");
    pulse_clr();
    check_state("par.clr");
    // clear coinciding with a new parity error leaves the flag set
    send_frame(9'h0C4, 8, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, e_s, e_s1);
    model_frame(8'hC4, 1'b1, 1'b1, 1'b1, 1'b0);
    check_state("par.coinc");
    pulse_clr();
    parity_en = 1'b0; parity_odd = 1'b0;

    // bad stop then a held-low break: one frame error only
    send_frame(9'h055, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, e_s, e_s1);
    model_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
    check_state("brk");
    pulse_clr();
    repeat (50 * 10) @(negedge clk);
    check_state("brk.hold");
    line = 1'b1;
    repeat (25) @(negedge clk);
    check_state("brk.release");
    good_frame(8'h96, "brk.next");
    do_pull("brk.next");

    // fill, overrun, simultaneous push/pull while full and while empty
    fill = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    for (int i = 0; i < 5; i++) good_frame(fill[i], "fill");
    chk("fill.full", rx_full, 1'b1);
    chk("fill.ov", overrun, 1'b1);
    pulse_clr();
    send_frame(9'h066, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, e_s, e_s1);
    model_frame(8'h66, 1'b0, 1'b0, 1'b1, 1'b1);
    check_state("full.pushpull");
    for (int i = 0; i < 4; i++) do_pull("drain");
    check_state("drained");
    send_frame(9'h077, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, e_s, e_s1);
    model_frame(8'h77, 1'b0, 1'b0, 1'b1, 1'b1);
    check_state("empty.pushpull");

    // reset in the middle of DATA wipes FIFO, flags and the frame
    send_frame(9'h012, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, e_s, e_s1);
    model_frame(8'h12, 1'b0, 1'b0, 1'b0, 1'b0);
    check_state("pre_rst");
    @(negedge clk); line = 1'b0;
    repeat (10) @(negedge clk); line = 1'b1;
    repeat (10) @(negedge clk); line = 1'b0;
    repeat (15) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    mq.delete(); m_fe = 1'b0; m_pe = 1'b0; m_ov = 1'b0;
    check_state("mid_rst");
    reset = 1'b0; line = 1'b1;
    repeat (130) @(negedge clk);
    check_state("post_rst");
    good_frame(8'h3C, "rst.3c");
    do_pull("rst.3c");

    // 7-bit build
    sel7 = 1'b1;
    send_frame(9'h07F, 7, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, e_s, e_s1);
    chk("db7.dout", dout7, 7'h7F);
    chk("db7.empty", rx_empty7, 1'b0);
    chk("db7.fe", frame_err7, 1'b0);
    chk("db7.pe", parity_err7, 1'b0);
    sel7 = 1'b0;
    check_state("db7.other");

    // random frames
    for (int n = 0; n < 40; n++) begin
      logic [7:0] d;
      bit pen, podd, badp, stop, psame;
      int np;
      div  = DW'($urandom_range(3, 12));
      pen  = 1'($urandom_range(0, 1));
      podd = 1'($urandom_range(0, 1));
      d    = 8'($urandom);
      badp = pen && ($urandom_range(0, 5) == 0);
      stop = ($urandom_range(0, 7) != 0);
      psame = ($urandom_range(0, 5) == 0);
      np   = $urandom_range(0, 2);
      parity_en = pen; parity_odd = podd;
      for (int k = 0; k < np; k++) do_pull("rnd.pull");
      if ($urandom_range(0, 5) == 0) pulse_clr();
      send_frame({1'b0, d}, 8, pen, podd, badp, stop, 1'b0, psame, 1'b0, e_s, e_s1);
      model_frame(d, pen, badp, stop, psame);
      check_state("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
